// File: rtl/mcp3008.sv
`default_nettype none
// ============================================================================
// Module   : mcp3008
// Purpose  : Round-robin poller for an MCP3008 SPI ADC; SCLK = CLK50/128.
// Options  : define MCP3008_DIFF_EN for differential conversions.
// Revision : 1.0 - initial release
// ============================================================================
module mcp3008 #(
    parameter int SCLK_N     = 7,
    parameter int N          = 10,
    parameter int CHANNELS   = 2,
    parameter int FRAME_BITS = 24
) (
    input  logic                         CLK50,
    input  logic                         reset,
    input  logic                         SPI_IN,
    output logic                         SPI_OUT,
    output logic                         SCLK,
    output logic                         CS_n,
    output logic [CHANNELS-1:0][N-1:0]   adc_out
);

    localparam int CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int BW        = $clog2(FRAME_BITS);
    localparam int START_POS = FRAME_BITS - 8;

    localparam logic [SCLK_N-1:0] CNT_RISE = {1'b0, {(SCLK_N-1){1'b1}}};
    localparam logic [SCLK_N-1:0] CNT_WRAP = {SCLK_N{1'b1}};
    localparam logic [BW-1:0]     BIT_LAST = BW'(FRAME_BITS - 1);
    localparam logic [CW-1:0]     CH_LAST  = CW'(CHANNELS - 1);

`ifdef MCP3008_DIFF_EN
    localparam logic SGL_DIFF = 1'b0;
`else
    localparam logic SGL_DIFF = 1'b1;
`endif

    typedef enum logic [0:0] {
        ST_GAP  = 1'b0,
        ST_XFER = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [SCLK_N-1:0]            cnt_q, cnt_d;
    logic                         gap_q, gap_d;
    logic [BW-1:0]                bit_q, bit_d;
    logic [FRAME_BITS-1:0]        sh_q, sh_d;
    logic                         done_q, done_d;
    logic [CW-1:0]                ch_q, ch_d;
    logic                         cs_n_q, cs_n_d;
    logic                         mosi_q, mosi_d;
    logic [CHANNELS-1:0][N-1:0]   adc_q, adc_d;

    logic                         w_rise;
    logic                         w_fall;
    logic [FRAME_BITS-1:0]        w_cmd;

    assign w_rise = (cnt_q == CNT_RISE);
    assign w_fall = (cnt_q == CNT_WRAP);

    // Command word: start bit, SGL/DIFF, then the 3-bit channel select.
    always_comb begin
        w_cmd                    = '0;
        w_cmd[START_POS]         = 1'b1;
        w_cmd[START_POS-1]       = SGL_DIFF;
        w_cmd[START_POS-2 -: 3]  = 3'(ch_q);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        gap_d   = gap_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        done_d  = 1'b0;
        ch_d    = ch_q;
        cs_n_d  = cs_n_q;
        mosi_d  = mosi_q;
        adc_d   = adc_q;

        // Result is committed one cycle after the final sample, before ch advances.
        if (done_q) begin
            adc_d[ch_q] = sh_q[N-1:0];
        end

        case (state_q)
            ST_GAP: begin
                if (w_fall) begin
                    if (gap_q) begin
                        state_d = ST_XFER;
                        gap_d   = 1'b0;
                        bit_d   = BIT_LAST;
                        cs_n_d  = 1'b0;
                        mosi_d  = w_cmd[BIT_LAST];
                    end else begin
                        gap_d   = 1'b1;
                    end
                end
            end
            ST_XFER: begin
                if (w_rise) begin
                    sh_d   = (sh_q << 1) | FRAME_BITS'(SPI_IN);
                    done_d = (bit_q == '0);
                end
                if (w_fall) begin
                    if (bit_q == '0) begin
                        state_d = ST_GAP;
                        cs_n_d  = 1'b1;
                        mosi_d  = 1'b0;
                        ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    end else begin
                        bit_d   = bit_q - 1'b1;
                        mosi_d  = w_cmd[bit_q - 1'b1];
                    end
                end
            end
            default: begin
                state_d = ST_GAP;
            end
        endcase
    end

    always_ff @(posedge CLK50) begin
        if (reset) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            gap_q   <= 1'b0;
            bit_q   <= '0;
            sh_q    <= '0;
            done_q  <= 1'b0;
            ch_q    <= '0;
            cs_n_q  <= 1'b1;
            mosi_q  <= 1'b0;
            adc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            done_q  <= done_d;
            ch_q    <= ch_d;
            cs_n_q  <= cs_n_d;
            mosi_q  <= mosi_d;
            adc_q   <= adc_d;
        end
    end

    assign SCLK    = cnt_q[SCLK_N-1];
    assign CS_n    = cs_n_q;
    assign SPI_OUT = mosi_q;
    assign adc_out = adc_q;

endmodule
`default_nettype wire

// File: tb/tb_mcp3008.sv
`default_nettype none
// ============================================================================
// Module   : tb_mcp3008
// Purpose  : Self-checking bench: behavioural ADC + frame-level scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mcp3008;

    localparam int CH = 2;
    localparam int NB = 10;

`ifdef MCP3008_DIFF_EN
    localparam int SGL = 0;
`else
    localparam int SGL = 1;
`endif

    logic                   CLK50 = 1'b0;
    logic                   reset = 1'b1;
    logic                   SPI_IN = 1'b0;
    logic                   SPI_OUT;
    logic                   SCLK;
    logic                   CS_n;
    logic [CH-1:0][NB-1:0]  adc_out;

    int          total = 0;
    int          bad   = 0;
    logic [NB-1:0] exp_adc [CH];
    int          exp_ch;
    logic        prev_sclk;
    bit          gap_ok;

    mcp3008 dut (
        .CLK50   (CLK50),
        .reset   (reset),
        .SPI_IN  (SPI_IN),
        .SPI_OUT (SPI_OUT),
        .SCLK    (SCLK),
        .CS_n    (CS_n),
        .adc_out (adc_out)
    );

    always #10 CLK50 = ~CLK50;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Expected MOSI frame: start bit at 16, SGL/DIFF at 15, channel at 14..12.
    function automatic logic [31:0] cmd_word(input int ch);
        return 32'((1 << 16) + (SGL << 15) + (ch << 12));
    endfunction

    task automatic model_reset();
        foreach (exp_adc[i]) exp_adc[i] = '0;
        exp_ch = 0;
    endtask

    // Plays the ADC for one frame; abort_bit >= 0 asserts reset during that bit.
    task automatic run_frame(input logic [23:0] miso, input int abort_bit);
        int          n;
        int          idx;
        int          rises;
        int          since;
        int          pmin;
        int          pmax;
        bit          seen;
        logic [23:0] mosi;

        n = 0;
        while (CS_n !== 1'b0 && n < 1000) begin
            @(negedge CLK50);
            n++;
        end
        if (CS_n !== 1'b0) begin
            check("cs_low_timeout", 32'd0, 32'd1);
            return;
        end
        if (gap_ok) check("gap_len", n, 256);

        prev_sclk = SCLK;
        idx   = 23;
        SPI_IN = miso[23];
        rises = 0;
        mosi  = '0;
        pmin  = 1 << 30;
        pmax  = 0;
        since = 0;
        seen  = 1'b0;
        n     = 0;
        while (CS_n === 1'b0 && n < 4000) begin
            @(negedge CLK50);
            n++;
            since++;
            if (SCLK && !prev_sclk) begin
                rises++;
                mosi = {mosi[22:0], SPI_OUT};
                if (seen) begin
                    if (since < pmin) pmin = since;
                    if (since > pmax) pmax = since;
                end
                seen  = 1'b1;
                since = 0;
            end
            if (!SCLK && prev_sclk && CS_n === 1'b0) begin
                idx--;
                if (idx >= 0) SPI_IN = miso[idx];
                if (idx == abort_bit) begin
                    repeat (10) @(negedge CLK50);
                    reset = 1'b1;
                    @(negedge CLK50);
                    check("abort_cs_n", CS_n, 1);
                    check("abort_sclk", SCLK, 0);
                    check("abort_adc0", adc_out[0], 0);
                    check("abort_adc1", adc_out[1], 0);
                    repeat (3) @(negedge CLK50);
                    reset  = 1'b0;
                    SPI_IN = 1'b0;
                    model_reset();
                    gap_ok = 1'b0;
                    return;
                end
            end
            prev_sclk = SCLK;
        end
        if (CS_n !== 1'b1) begin
            check("frame_timeout", 32'd0, 32'd1);
            return;
        end

        check("rises", rises, 24);
        check("mosi", 32'(mosi), cmd_word(exp_ch));
        check("sclk_period_min", pmin, 128);
        check("sclk_period_max", pmax, 128);

        exp_adc[exp_ch] = miso[9:0];
        exp_ch = (exp_ch + 1) % CH;
        check("adc0", 32'(adc_out[0]), 32'(exp_adc[0]));
        check("adc1", 32'(adc_out[1]), 32'(exp_adc[1]));
        SPI_IN = 1'b0;
        gap_ok = 1'b1;
    endtask

    initial begin
        model_reset();
        gap_ok = 1'b0;
        reset  = 1'b1;
        repeat (5) @(negedge CLK50);
        check("rst_cs_n", CS_n, 1);
        check("rst_spi_out", SPI_OUT, 0);
        reset = 1'b0;
        repeat (20) @(negedge CLK50);
        check("idle_adc", 32'(adc_out), 32'd0);
        check("idle_cs_n", CS_n, 1);
        check("idle_sclk", SCLK, 0);

        run_frame(24'h8001D3, -1);
        run_frame(24'h8003F2, -1);
        for (int i = 0; i < 4; i++) run_frame(24'($urandom), -1);
        run_frame(24'($urandom), 5);
        for (int i = 0; i < 3; i++) run_frame(24'($urandom), -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
